// File: rtl/raw10_depacker.sv
// RAW10 depacker: turns a 4-lane MIPI byte stream into 4 x 10-bit pixels per 5-byte group.
// Optional build macro RAW10_DEPACK_ERR_EN adds error_o (line ended mid-group).
module raw10_depacker #(
    parameter int LANES = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        line_valid_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        line_valid_o,
    output logic        output_valid_o,
`ifdef RAW10_DEPACK_ERR_EN
    output logic [39:0] output_o,
    output logic        error_o
`else
    output logic [39:0] output_o
`endif
);

    if (LANES != 4) begin : g_lanes_check
        $error("raw10_depacker supports LANES == 4 only");
    end

    // State names give the number of residual bytes held in r_res.
    typedef enum logic [2:0] {
        StRes0 = 3'd0,
        StRes4 = 3'd1,
        StRes3 = 3'd2,
        StRes2 = 3'd3,
        StRes1 = 3'd4
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [31:0] r_res;
    logic [31:0] w_res_d;
    logic [39:0] w_grp;
    logic        w_grp_vld;
    logic [39:0] w_pix;
    logic        w_accept;
    logic        r_out_vld;
    logic [39:0] r_out;
    logic        r_lv;

    assign w_accept = line_valid_i & data_valid_i;

    // Group bytes are packed earliest-first from bit 0: byte k at [8k+7:8k].
    always_comb begin
        w_state_d = r_state;
        w_res_d   = r_res;
        w_grp     = '0;
        w_grp_vld = 1'b0;
        if (!line_valid_i) begin
            w_state_d = StRes0;
            w_res_d   = '0;
        end else if (w_accept) begin
            unique case (r_state)
                StRes0: begin
                    w_res_d   = data_i;
                    w_state_d = StRes4;
                end
                StRes4: begin
                    w_grp     = {data_i[7:0], r_res};
                    w_res_d   = {8'h00, data_i[31:8]};
                    w_grp_vld = 1'b1;
                    w_state_d = StRes3;
                end
                StRes3: begin
                    w_grp     = {data_i[15:0], r_res[23:0]};
                    w_res_d   = {16'h0000, data_i[31:16]};
                    w_grp_vld = 1'b1;
                    w_state_d = StRes2;
                end
                StRes2: begin
                    w_grp     = {data_i[23:0], r_res[15:0]};
                    w_res_d   = {24'h000000, data_i[31:24]};
                    w_grp_vld = 1'b1;
                    w_state_d = StRes1;
                end
                StRes1: begin
                    w_grp     = {data_i, r_res[7:0]};
                    w_res_d   = '0;
                    w_grp_vld = 1'b1;
                    w_state_d = StRes0;
                end
                default: begin
                    w_res_d   = '0;
                    w_state_d = StRes0;
                end
            endcase
        end
    end

    // Pixel n = {Bn, B4[2n+1:2n]}; pixel 0 lands in the top field.
    assign w_pix = {w_grp[7:0],   w_grp[33:32],
                    w_grp[15:8],  w_grp[35:34],
                    w_grp[23:16], w_grp[37:36],
                    w_grp[31:24], w_grp[39:38]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StRes0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_d;
            r_res   <= w_res_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_out_vld <= 1'b0;
            r_out     <= '0;
            r_lv      <= 1'b0;
        end else begin
            r_out_vld <= w_grp_vld;
            r_lv      <= line_valid_i;
            if (w_grp_vld) begin
                r_out <= w_pix;
            end
        end
    end

    assign line_valid_o   = r_lv;
    assign output_valid_o = r_out_vld;
    assign output_o       = r_out;

`ifdef RAW10_DEPACK_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_lv & ~line_valid_i & (r_state != StRes0);
        end
    end

    assign error_o = r_err;
`endif

endmodule

// File: tb/tb_raw10_depacker.sv
// Bench for raw10_depacker: directed scenarios plus random lines, checked against
// a byte-queue reference model.
module tb_raw10_depacker;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        line_valid_i;
    logic        data_valid_i;
    logic [31:0] data_i;
    logic        line_valid_o;
    logic        output_valid_o;
    logic [39:0] output_o;
`ifdef RAW10_DEPACK_ERR_EN
    logic        error_o;
`endif

    raw10_depacker #(.LANES(4)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .line_valid_i   (line_valid_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .line_valid_o   (line_valid_o),
        .output_valid_o (output_valid_o),
`ifdef RAW10_DEPACK_ERR_EN
        .output_o       (output_o),
        .error_o        (error_o)
`else
        .output_o       (output_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: bytes of the current line not yet formed into a group.
    logic [7:0]  q[$];
    logic [39:0] last_out;
    logic        prev_lv;
    int          n_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_out = '0;
        prev_lv  = 1'b0;
    endtask

    // One clock: drive, step past the edge, update the model, compare.
    task automatic cyc(input logic lv, input logic dv, input logic [31:0] d);
        logic       exp_vld;
        logic       exp_err;
        logic [7:0] g[5];
        logic [9:0] pix;
        line_valid_i = lv;
        data_valid_i = dv;
        data_i       = d;
        @(posedge clk_i);
        #1;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (!lv) begin
            exp_err = prev_lv && (q.size() != 0);
            q.delete();
        end else if (dv) begin
            for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
            if (q.size() >= 5) begin
                for (int i = 0; i < 5; i++) g[i] = q.pop_front();
                for (int n = 0; n < 4; n++) begin
                    pix = {g[n], g[4][2*n +: 2]};
                    last_out[39-10*n -: 10] = pix;
                end
                exp_vld = 1'b1;
            end
        end
        prev_lv = lv;
        if (exp_vld) n_valid++;
        check("output_valid", 64'(output_valid_o), 64'(exp_vld));
        check("output", 64'(output_o), 64'(last_out));
        check("line_valid_o", 64'(line_valid_o), 64'(lv));
`ifdef RAW10_DEPACK_ERR_EN
        check("error", 64'(error_o), 64'(exp_err));
`endif
    endtask

    logic [39:0] fixed_exp;
    logic [31:0] inc_words[5];

    initial begin
        line_valid_i = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;
        reset_i      = 1'b1;
        model_reset();
        #12;
        check("reset_valid", 64'(output_valid_o), 64'd0);
        check("reset_output", 64'(output_o), 64'd0);
        check("reset_lv", 64'(line_valid_o), 64'd0);
        reset_i = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);

        // Single group from two words.
        cyc(1'b1, 1'b1, 32'h44332211);
        cyc(1'b1, 1'b1, {$urandom_range(0, 32'hFFFFFF), 8'hE4} & 32'hFFFFFFFF);
        fixed_exp = {10'h044, 10'h089, 10'h0CE, 10'h113};
        check("single_group", 64'(output_o), 64'(fixed_exp));
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);

        // Steady stream of incrementing bytes, then the same words with gaps.
        for (int w = 0; w < 5; w++)
            inc_words[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
        n_valid = 0;
        for (int w = 0; w < 5; w++) cyc(1'b1, 1'b1, inc_words[w]);
        check("stream_count", 64'(n_valid), 64'd4);
        check("stream_last_p0", 64'(output_o[39:32]), 64'h0F);
        cyc(1'b0, 1'b0, 32'h0);
        n_valid = 0;
        for (int w = 0; w < 5; w++) begin
            cyc(1'b1, 1'b1, inc_words[w]);
            cyc(1'b1, 1'b0, $urandom);
        end
        check("gap_count", 64'(n_valid), 64'd4);
        cyc(1'b0, 1'b0, 32'h0);

        // Short line: 3 words give 2 groups and a line-end error.
        n_valid = 0;
        for (int w = 0; w < 3; w++) cyc(1'b1, 1'b1, $urandom);
        cyc(1'b0, 1'b0, 32'h0);
        check("short_count", 64'(n_valid), 64'd2);
        cyc(1'b0, 1'b0, 32'h0);

        // Discard while line_valid_i is low, then a fresh group.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom);
        cyc(1'b1, 1'b1, $urandom);
        cyc(1'b1, 1'b1, $urandom);
        cyc(1'b0, 1'b0, 32'h0);

        // Asynchronous reset while three residual bytes are held.
        cyc(1'b1, 1'b1, $urandom);
        cyc(1'b1, 1'b1, $urandom);
        #2;
        reset_i = 1'b1;
        #1;
        check("async_rst_valid", 64'(output_valid_o), 64'd0);
        check("async_rst_output", 64'(output_o), 64'd0);
        check("async_rst_lv", 64'(line_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        model_reset();
        cyc(1'b1, 1'b1, 32'h44332211);
        cyc(1'b1, 1'b1, 32'h000000E4);
        check("post_rst_group", 64'(output_o), 64'(fixed_exp));
        cyc(1'b0, 1'b0, 32'h0);

        // Random lines with random data_valid gaps.
        for (int ln = 0; ln < 40; ln++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++)
                cyc(1'b1, 1'($urandom_range(0, 3) != 0), $urandom);
            for (int c = 0; c < $urandom_range(1, 3); c++)
                cyc(1'b0, 1'($urandom_range(0, 1)), $urandom);
        end

        // Contiguous bursts: floor(4N/5) groups.
        for (int b = 0; b < 6; b++) begin
            int nw;
            nw = $urandom_range(5, 23);
            n_valid = 0;
            for (int w = 0; w < nw; w++) cyc(1'b1, 1'b1, $urandom);
            check("burst_count", 64'(n_valid), 64'((4 * nw) / 5));
            cyc(1'b0, 1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
